// File: rtl/dma_guard_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_guard_arbiter: two-channel DMA burst arbiter that blocks beats aimed  |
// | at protected stack/data and key regions and forces a kill/reset on hit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_guard_arbiter #(
  parameter logic [15:0] SDATA_BASE    = 16'h0400,
  parameter logic [15:0] SDATA_SIZE    = 16'h0C00,
  parameter logic [15:0] KMEM_BASE     = 16'h6A00,
  parameter logic [15:0] KMEM_SIZE     = 16'h0040,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic        ch0_req,
  input  logic [15:0] ch0_addr,
  input  logic [3:0]  ch0_len,
  input  logic        ch1_req,
  input  logic [15:0] ch1_addr,
  input  logic [3:0]  ch1_len,
  output logic        ch0_gnt,
  output logic        ch1_gnt,
  output logic        ch0_done,
  output logic        ch1_done,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  input  logic        dma_ready,
  output logic        viol,
  output logic        viol_ch,
  output logic        kill_reset
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    KILL  = 2'd2
  } state_t;

  // Region ends computed in 17 bits so a region touching 16'hFFFF cannot wrap.
  localparam logic [16:0] SDATA_END = {1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE};
  localparam logic [16:0] KMEM_END  = {1'b0, KMEM_BASE} + {1'b0, KMEM_SIZE};

  state_t      state, state_nxt;
  logic [15:0] cur_addr, cur_addr_nxt;
  logic [3:0]  remaining, remaining_nxt;
  logic        owner, owner_nxt;
  logic        last_gnt, last_gnt_nxt;
  logic        viol_nxt, viol_ch_nxt;
  logic        done0_nxt, done1_nxt;
  logic        sel;
  logic        hit_sdata, hit_kmem, hit;

  assign hit_sdata = ({1'b0, cur_addr} >= {1'b0, SDATA_BASE}) && ({1'b0, cur_addr} < SDATA_END);
  assign hit_kmem  = ({1'b0, cur_addr} >= {1'b0, KMEM_BASE})  && ({1'b0, cur_addr} < KMEM_END);
  assign hit       = hit_sdata || hit_kmem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= KILL;
      cur_addr  <= 16'h0000;
      remaining <= 4'd0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      viol      <= 1'b0;
      viol_ch   <= 1'b0;
      ch0_done  <= 1'b0;
      ch1_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      owner     <= owner_nxt;
      last_gnt  <= last_gnt_nxt;
      viol      <= viol_nxt;
      viol_ch   <= viol_ch_nxt;
      ch0_done  <= done0_nxt;
      ch1_done  <= done1_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    owner_nxt     = owner;
    last_gnt_nxt  = last_gnt;
    viol_nxt      = 1'b0;
    viol_ch_nxt   = viol_ch;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    ch0_gnt       = 1'b0;
    ch1_gnt       = 1'b0;
    dma_en        = 1'b0;
    kill_reset    = 1'b0;
    sel           = 1'b0;

    case (state)
      IDLE: begin
        if (ch0_req || ch1_req) begin
          // On a tie the channel not granted last time wins.
          sel           = (ch0_req && ch1_req) ? ~last_gnt : ch1_req;
          ch0_gnt       = ~sel;
          ch1_gnt       = sel;
          cur_addr_nxt  = sel ? ch1_addr : ch0_addr;
          remaining_nxt = sel ? ch1_len  : ch0_len;
          owner_nxt     = sel;
          last_gnt_nxt  = sel;
          state_nxt     = BURST;
        end
      end

      BURST: begin
        if (hit) begin
          viol_nxt    = 1'b1;
          viol_ch_nxt = owner;
          state_nxt   = KILL;
        end else begin
          dma_en = 1'b1;
          if (dma_ready) begin
            if (remaining == 4'd0) begin
              done0_nxt = ~owner;
              done1_nxt = owner;
              state_nxt = IDLE;
            end else begin
              cur_addr_nxt  = cur_addr + 16'd1;
              remaining_nxt = remaining - 4'd1;
            end
          end
        end
      end

      KILL: begin
        kill_reset = 1'b1;
        if (pc == RESET_HANDLER) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = KILL;
      end
    endcase
  end

  assign dma_addr = dma_en ? cur_addr : 16'h0000;

endmodule
`default_nettype wire

// File: doc/dma_guard_arbiter.md
DMA_GUARD_ARBITER -- requirements
Module: dma_guard_arbiter

Interface
REQ-001 Parameter SDATA_BASE, 16'h0400, base of protected stack/data region.
REQ-002 Parameter SDATA_SIZE, 16'h0C00, size of protected stack/data region.
REQ-003 Parameter KMEM_BASE, 16'h6A00, base of protected key region.
REQ-004 Parameter KMEM_SIZE, 16'h0040, size of protected key region.
REQ-005 Parameter RESET_HANDLER, 16'h0000, PC value that releases KILL.
REQ-006 Ports SHALL be as follows; one clock; reset is synchronous and active-low:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- pc  in  16  CPU program counter
- ch0_req / ch1_req  in  1  burst request, held until grant
- ch0_addr / ch1_addr  in  16  burst start address, sampled at grant
- ch0_len / ch1_len  in  4  burst length minus one (1..16 beats), sampled at grant
- ch0_gnt / ch1_gnt  out  1  one-cycle grant pulse
- ch0_done / ch1_done  out  1  one-cycle burst-complete pulse
- dma_addr  out  16  shared DMA port address
- dma_en  out  1  shared DMA port beat valid
- dma_ready  in  1  bus accepts current beat
- viol  out  1  one-cycle violation pulse
- viol_ch  out  1  channel of last violation, held until next violation
- kill_reset  out  1  system reset request, high while in KILL

Function
REQ-007 FSM states SHALL be IDLE, BURST, KILL.
REQ-008 IDLE: if any request, SHALL grant one channel; both requesting -> channel other than last_gnt wins; single request -> that channel.
REQ-009 On grant, SHALL latch cur_addr=chX_addr, remaining=chX_len, owner=X, pulse chX_gnt for exactly one cycle, update last_gnt=X, enter BURST next cycle.
REQ-010 A protected hit SHALL be cur_addr in [SDATA_BASE, SDATA_BASE+SDATA_SIZE) or [KMEM_BASE, KMEM_BASE+KMEM_SIZE), lower bound inclusive, upper bound exclusive, 16-bit unsigned compare.
REQ-011 BURST, no hit: dma_en=1, dma_addr=cur_addr (combinational from registers).
REQ-012 BURST, hit: dma_en SHALL be 0 in that cycle (beat never issued), viol pulses 1 next cycle, viol_ch=owner, state -> KILL; chX_done SHALL NOT pulse.
REQ-013 BURST, dma_en=1 and dma_ready=0: SHALL hold cur_addr, remaining, dma_addr stable.
REQ-014 BURST, beat accepted and remaining!=0: cur_addr+1 (16'hFFFF wraps to 16'h0000), remaining-1.
REQ-015 BURST, beat accepted and remaining==0: pulse ch<owner>_done next cycle, return to IDLE; next grant no earlier than cycle after return (minimum 1 IDLE cycle between bursts).
REQ-016 KILL: kill_reset=1, dma_en=0, no grants, requests ignored.
REQ-017 KILL -> IDLE SHALL occur when pc==RESET_HANDLER; kill_reset deasserts the following cycle.
REQ-018 Hit check has priority over dma_ready in the same cycle.
REQ-019 dma_addr SHALL read 16'h0000 whenever dma_en=0.

Reset
REQ-020 reset_n=0 at a clock edge SHALL force state=KILL, kill_reset=1, last_gnt=1 (ch0 wins first tie), viol=0, viol_ch=0, all gnt/done=0, dma_en=0, cur_addr=0, remaining=0.
REQ-021 Reset mid-burst SHALL abandon the burst with no done pulse; exit from reset-induced KILL follows REQ-017.

Verification
REQ-022 Reset, pc=0x0000 -> kill_reset=1 during reset, 0 one cycle after reset_n=1 and IDLE entered.
REQ-023 ch0_req, addr=0x2000, len=3, dma_ready=1 -> ch0_gnt 1 cycle; dma_addr 0x2000..0x2003 on 4 consecutive cycles; ch0_done once; no viol.
REQ-024 Both requests, last_gnt=0 -> ch1 granted first, ch0 after ch1_done; ch0 then ch1 on next tie.
REQ-025 ch1 addr=0x03FE, len=3 -> beats 0x03FE, 0x03FF issued; 0x0400 suppressed (dma_en=0); viol=1, viol_ch=1, kill_reset=1 until pc=0x0000.
REQ-026 ch0 addr=0xFFFF, len=1 -> beats 0xFFFF, 0x0000; dma_ready low 2 cycles on second beat holds dma_addr=0x0000; done after acceptance.
REQ-027 Boundaries: addr=0x0FFF -> violation; 0x1000 -> no violation; 0x6A3F -> violation; 0x6A40 -> no violation.
